// File: rtl/psi_serial_receiver.sv
// PSI serial link receiver: deframes start/payload/flag/stop frames from data_s
// into DATA_WIDTH-bit words presented on a single-entry valid/ready output register.
module psi_serial_receiver #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_serial,
    input  logic                  rst_n,
    input  logic                  data_s,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data_p,
    output logic                  pktend,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overflow
);

    localparam int unsigned    CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_FLAG = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  flag_q, flag_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  pktend_q, pktend_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overflow_q, overflow_d;
    logic                  commit;

    // Deframing FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        flag_d      = flag_q;
        commit      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!data_s) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                shift_d[cnt_q] = data_s;
                if (cnt_q == CNT_LAST) begin
                    // Clear rather than increment so cnt never wraps past the last bit.
                    cnt_d   = '0;
                    state_d = S_FLAG;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FLAG: begin
                flag_d  = data_s;
                state_d = S_STOP;
            end
            S_STOP: begin
                state_d = S_IDLE;
                if (data_s) begin
                    commit = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output holding register: a transfer and a commit may coincide on one edge,
    // in which case the incoming word replaces the one just consumed.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        pktend_d   = pktend_q;
        overflow_d = 1'b0;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (commit) begin
            if (!valid_q || ready) begin
                valid_d  = 1'b1;
                data_d   = shift_q;
                pktend_d = flag_q;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_serial or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            flag_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            pktend_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            flag_q      <= flag_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            pktend_q    <= pktend_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign valid     = valid_q;
    assign data_p    = data_q;
    assign pktend    = pktend_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule
